mer_meter_qam: RTL and testbench

Parametrised symbol-rate slicer and modulation-error-ratio (MER) meter for square M-QAM. It sits after the channel (the black-box MER device, the channel model, or a bypass) on the in-phase and quadrature decision variables. It estimates the constellation reference level, slices both rails, and accumulates mean error power and mean signal power over a 2^WIN_LOG2-symbol window. It generalises the fixed 16-QAM flow: LEVELS per axis is a parameter, it estimates its own reference level, and it supports single-shot and continuous measurement modes.

---
 rtl/mer_meter_qam.sv | 207 ++++++++++++++++++++
 tb/tb_mer_meter_qam.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mer_meter_qam.sv
// Square M-QAM slicer and MER meter: acquires the reference level, then averages error and signal power over 2^WIN_LOG2 symbols.
// Define MER_METER_DC_EN to also estimate the per-rail DC offset during ACQ_REF and remove it before slicing.
module mer_meter_qam #(
  parameter int DATA_WIDTH = 18,
  parameter int LEVELS     = 4,
  parameter int WIN_LOG2   = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sym_en,
  input  logic                  start,
  input  logic                  cont,
  input  logic [DATA_WIDTH-1:0] I_in,
  input  logic [DATA_WIDTH-1:0] Q_in,
  output logic [DATA_WIDTH-1:0] I_dec,
  output logic [DATA_WIDTH-1:0] Q_dec,
  output logic [DATA_WIDTH-1:0] ref_level,
  output logic [DATA_WIDTH-1:0] mean_err_power,
  output logic [DATA_WIDTH-1:0] mean_sig_power,
  output logic                  busy,
  output logic                  done
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = DATA_WIDTH + WIN_LOG2 + 1;
  localparam int LG = $clog2(LEVELS);

  typedef logic [DW-1:0]        word_t;
  typedef logic signed [DW:0]   err_t;
  typedef logic signed [DW+3:0] wide_t;
  typedef logic [AW-1:0]        acc_t;
  typedef logic [WIN_LOG2:0]    cnt_t;
  typedef enum logic [1:0] {IDLE, ACQ_REF, MEASURE, DONE} state_t;

  localparam cnt_t  ACQ_LAST  = cnt_t'((1 << WIN_LOG2) - 1);
  localparam cnt_t  MEAS_LAST = cnt_t'(1 << WIN_LOG2);
  localparam wide_t POS_MAX   = {5'b00000, {(DW-1){1'b1}}};
  localparam wide_t NEG_MIN   = {5'b11111, {(DW-1){1'b0}}};

  function automatic word_t abs_sat(input word_t v);
    if (v[DW-1] && v[DW-2:0] == '0) return {1'b0, {(DW-1){1'b1}}};
    return v[DW-1] ? word_t'(-v) : v;
  endfunction

  function automatic word_t sat_word(input wide_t v);
    if (v > POS_MAX) return POS_MAX[DW-1:0];
    if (v < NEG_MIN) return NEG_MIN[DW-1:0];
    return v[DW-1:0];
  endfunction

  // Index = number of thresholds (2j-LEVELS)*a at or below x, so ties land on the higher level.
  function automatic word_t slice(input word_t x, input word_t step);
    wide_t a, xw;
    int    k;
    a  = wide_t'({1'b0, step});
    xw = wide_t'($signed(x));
    k  = 0;
    for (int j = 1; j < LEVELS; j++)
      if (xw >= a * wide_t'(2 * j - LEVELS)) k++;
    return sat_word(a * wide_t'(2 * k - LEVELS + 1));
  endfunction

  function automatic word_t square_sat(input err_t v);
    logic signed [2*DW+1:0] vw, p;
    vw = {{(DW+1){v[DW]}}, v};
    p  = (vw * vw) >>> (DW - 1);
    if (p[2*DW+1:DW] != '0) return '1;
    return p[DW-1:0];
  endfunction

  function automatic word_t mean_sat(input acc_t v);
    acc_t s;
    s = v >> WIN_LOG2;
    if (s[AW-1:DW] != '0) return '1;
    return s[DW-1:0];
  endfunction

  state_t state;
  cnt_t   cnt;
  acc_t   acc_ref, acc_err, acc_sig;
  acc_t   ref_sum, err_sum, sig_sum;
  word_t  xi_reg, xq_reg;
  word_t  xi_eff, xq_eff, step, dec_i_nx, dec_q_nx;

`ifdef MER_METER_DC_EN
  typedef logic signed [DW+WIN_LOG2-1:0] dc_acc_t;
  dc_acc_t acc_dc_i, acc_dc_q, dc_sum_i, dc_sum_q;
  word_t   dc_i, dc_q;
`endif

  always_comb begin
    // NOTE: every combinational result gets a default first so no path leaves it unassigned and infers a latch.
    xi_eff = I_in;
    xq_eff = Q_in;
`ifdef MER_METER_DC_EN
    xi_eff   = sat_word(wide_t'($signed(I_in)) - wide_t'($signed(dc_i)));
    xq_eff   = sat_word(wide_t'($signed(Q_in)) - wide_t'($signed(dc_q)));
    dc_sum_i = acc_dc_i + dc_acc_t'($signed(I_in));
    dc_sum_q = acc_dc_q + dc_acc_t'($signed(Q_in));
`endif
    step     = (ref_level << 1) >> LG;
    dec_i_nx = slice(xi_eff, step);
    dec_q_nx = slice(xq_eff, step);
    ref_sum  = acc_ref + acc_t'(abs_sat(I_in)) + acc_t'(abs_sat(Q_in));
    err_sum  = acc_err
             + acc_t'(square_sat(err_t'($signed(xi_reg)) - err_t'($signed(I_dec))))
             + acc_t'(square_sat(err_t'($signed(xq_reg)) - err_t'($signed(Q_dec))));
    sig_sum  = acc_sig
             + acc_t'(square_sat(err_t'($signed(I_dec))))
             + acc_t'(square_sat(err_t'($signed(Q_dec))));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      acc_ref        <= '0;
      acc_err        <= '0;
      acc_sig        <= '0;
      xi_reg         <= '0;
      xq_reg         <= '0;
      I_dec          <= '0;
      Q_dec          <= '0;
      ref_level      <= '0;
      mean_err_power <= '0;
      mean_sig_power <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
`ifdef MER_METER_DC_EN
      acc_dc_i       <= '0;
      acc_dc_q       <= '0;
      dc_i           <= '0;
      dc_q           <= '0;
`endif
    end else if (sym_en) begin
      xi_reg <= xi_eff;
      xq_reg <= xq_eff;
      I_dec  <= dec_i_nx;
      Q_dec  <= dec_q_nx;
      case (state)
        IDLE: if (start) begin
          acc_ref <= '0;
          cnt     <= '0;
`ifdef MER_METER_DC_EN
          acc_dc_i <= '0;
          acc_dc_q <= '0;
`endif
          state   <= ACQ_REF;
          busy    <= 1'b1;
        end
        ACQ_REF: begin
          acc_ref <= ref_sum;
          cnt     <= cnt + cnt_t'(1);
`ifdef MER_METER_DC_EN
          acc_dc_i <= dc_sum_i;
          acc_dc_q <= dc_sum_q;
`endif
          if (cnt == ACQ_LAST) begin
            ref_level <= word_t'(ref_sum >> (WIN_LOG2 + 1));
`ifdef MER_METER_DC_EN
            dc_i <= word_t'(dc_sum_i >>> WIN_LOG2);
            dc_q <= word_t'(dc_sum_q >>> WIN_LOG2);
`endif
            cnt     <= '0;
            acc_err <= '0;
            acc_sig <= '0;
            state   <= MEASURE;
          end
        end
        MEASURE: begin
          cnt <= cnt + cnt_t'(1);
          // The first symbol only primes the pipeline with a sample sliced against the current reference.
          if (cnt != '0) begin
            acc_err <= err_sum;
            acc_sig <= sig_sum;
          end
          if (cnt == MEAS_LAST) begin
            mean_err_power <= mean_sat(err_sum);
            mean_sig_power <= mean_sat(sig_sum);
            state          <= DONE;
            busy           <= 1'b0;
            done           <= 1'b1;
          end
        end
        DONE: if (start) begin
          acc_ref <= '0;
          cnt     <= '0;
`ifdef MER_METER_DC_EN
          acc_dc_i <= '0;
          acc_dc_q <= '0;
`endif
          state   <= ACQ_REF;
          busy    <= 1'b1;
          done    <= 1'b0;
        end else if (cont) begin
          acc_err <= '0;
          acc_sig <= '0;
          cnt     <= '0;
          state   <= MEASURE;
          busy    <= 1'b1;
          done    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mer_meter_qam.sv
// Directed bench for mer_meter_qam (18-bit, 16-QAM, 16-symbol window); slicer decisions are checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_mer_meter_qam;
  localparam int DW       = 18;
  localparam int LEVELS   = 4;
  localparam int WIN_LOG2 = 4;
  localparam int WIN      = 16;
`ifdef MER_METER_DC_EN
  localparam int EXP_OFF_ERR = 0;
`else
  localparam int EXP_OFF_ERR = 16;
`endif

  logic          clk = 1'b0, reset = 1'b0, sym_en = 1'b0, start = 1'b0, cont = 1'b0;
  logic [DW-1:0] I_in = '0, Q_in = '0;
  logic [DW-1:0] I_dec, Q_dec, ref_level, mean_err_power, mean_sig_power;
  logic          busy, done;

  typedef struct { int i; int q; } dec_t;
  dec_t exp_q[$];
  int   checks = 0, errors = 0;
  int   m_ref = 0, m_dc_i = 0, m_dc_q = 0;
  int   pat[4] = '{16384, 49152, -16384, -49152};

  always #5 clk = ~clk;

  mer_meter_qam #(.DATA_WIDTH(DW), .LEVELS(LEVELS), .WIN_LOG2(WIN_LOG2)) dut (
    .clk(clk), .reset(reset), .sym_en(sym_en), .start(start), .cont(cont),
    .I_in(I_in), .Q_in(Q_in), .I_dec(I_dec), .Q_dec(Q_dec), .ref_level(ref_level),
    .mean_err_power(mean_err_power), .mean_sig_power(mean_sig_power),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int abs_sat(input int x);
    return (x == -131072) ? 131071 : (x < 0 ? -x : x);
  endfunction

  // Reference slicer written as floor division, independent of the threshold-count form.
  function automatic int model_dec(input int x, input int dc, input int rf);
    int xe, a, q, k;
    xe = clamp(x - dc, -131072, 131071);
    a  = (2 * rf) / LEVELS;
    if (a == 0) return 0;
    q = xe / (2 * a);
    if ((xe % (2 * a) != 0) && xe < 0) q--;
    k = clamp(q + LEVELS / 2, 0, LEVELS - 1);
    return clamp((2 * k - LEVELS + 1) * a, -131072, 131071);
  endfunction

  task automatic do_sym(input int xi, input int xq, input bit st = 1'b0, input bit ct = 1'b0);
    dec_t e, got;
    @(negedge clk);
    I_in   = DW'(xi);
    Q_in   = DW'(xq);
    sym_en = 1'b1;
    start  = st;
    cont   = ct;
    e.i = model_dec(xi, m_dc_i, m_ref);
    e.q = model_dec(xq, m_dc_q, m_ref);
    exp_q.push_back(e);
    @(negedge clk);
    sym_en = 1'b0;
    start  = 1'b0;
    cont   = 1'b0;
    I_in   = DW'($urandom);
    Q_in   = DW'($urandom);
    got = exp_q.pop_front();
    check("i_dec", $signed(I_dec), got.i);
    check("q_dec", $signed(Q_dec), got.q);
  endtask

  task automatic acquire(input bit hold_min, input int off);
    int sum_abs, sum_i, sum_q, xi, xq;
    sum_abs = 0; sum_i = 0; sum_q = 0;
    do_sym(pat[0] + off, pat[1] + off, 1'b1, 1'b0);
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
    for (int n = 0; n < WIN; n++) begin
      xi = hold_min ? -131072 : pat[n % 4] + off;
      xq = hold_min ? -131072 : pat[(n + 1) % 4] + off;
      sum_abs += abs_sat(xi) + abs_sat(xq);
      sum_i   += xi;
      sum_q   += xq;
      do_sym(xi, xq);
    end
    m_ref = sum_abs >>> (WIN_LOG2 + 1);
`ifdef MER_METER_DC_EN
    m_dc_i = sum_i >>> WIN_LOG2;
    m_dc_q = sum_q >>> WIN_LOG2;
`endif
  endtask

  task automatic measure(input int off, input bit mid_start, input int exp_err, input int exp_sig);
    for (int k = 0; k <= WIN; k++) begin
      do_sym(pat[k % 4] + off, pat[(k + 1) % 4] + off, mid_start && (k == WIN / 2), 1'b0);
      check("done_in_measure", done, k == WIN);
      check("busy_in_measure", busy, k != WIN);
    end
    check("mean_err_power", mean_err_power, exp_err);
    check("mean_sig_power", mean_sig_power, exp_sig);
  endtask

  initial begin
    #23;
    check("rst_i_dec", I_dec, 0);
    check("rst_q_dec", Q_dec, 0);
    check("rst_ref", ref_level, 0);
    check("rst_err", mean_err_power, 0);
    check("rst_sig", mean_sig_power, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;

    // Clean balanced pattern.
    acquire(1'b0, 0);
    check("ref_clean", ref_level, 32768);
    measure(0, 1'b0, 0, 20480);

    // Constant +1024 offset on both rails.
    acquire(1'b0, 1024);
    check("ref_offset", ref_level, 32768);
    measure(1024, 1'b0, EXP_OFF_ERR, 20480);

    // Continuous re-measure with the reference held; a start pulse mid-window is ignored.
    do_sym(pat[0] + 1024, pat[1] + 1024, 1'b0, 1'b1);
    check("busy_after_cont", busy, 1);
    check("done_after_cont", done, 0);
    check("ref_held_cont", ref_level, 32768);
    measure(1024, 1'b1, EXP_OFF_ERR, 20480);

    // Most-negative input during acquisition saturates the absolute value.
    acquire(1'b1, 0);
    check("ref_saturated", ref_level, 131071);
    for (int k = 0; k < 6; k++) do_sym(pat[k % 4], pat[(k + 1) % 4]);
    check("busy_mid_measure", busy, 1);

    // Asynchronous reset in the middle of the window.
    #2 reset = 1'b0;
    #1;
    check("arst_i_dec", I_dec, 0);
    check("arst_q_dec", Q_dec, 0);
    check("arst_ref", ref_level, 0);
    check("arst_err", mean_err_power, 0);
    check("arst_sig", mean_sig_power, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    m_ref = 0; m_dc_i = 0; m_dc_q = 0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      do_sym(pat[k % 4], pat[(k + 1) % 4]);
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
    end
    check("idle_err", mean_err_power, 0);
    check("idle_sig", mean_sig_power, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
